// File: rtl/pwm_pkg.sv
// Shared types for the centre-aligned PWM dead-time stage.
package pwm_pkg;

    // Gate-drive phase: one side on, or a dead band on the way to the other side.
    typedef enum logic [1:0] {
        LO_ON     = 2'd0,
        DEAD_RISE = 2'd1,
        HI_ON     = 2'd2,
        DEAD_FALL = 2'd3
    } pwm_state_t;

    // Starting in DEAD_FALL with an empty timer lets the FSM settle onto the
    // correct side one cycle after reset without ever driving both gates.
    localparam pwm_state_t PWM_RESET_STATE = DEAD_FALL;

endpackage

// File: rtl/deadtime_timer.sv
// Load/decrement dead-time counter with "last cycle" and "empty" flags.
module deadtime_timer #(
    parameter int DT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [DT_W-1:0] load_val,
    input  logic            dec,
    output logic            done,
    output logic            zero
);

    logic [DT_W-1:0] cnt;

    function automatic logic [DT_W-1:0] sat_dec(input logic [DT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    // Counter: load has priority over decrement; decrement never wraps below zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= sat_dec(cnt);
        end
    end

    assign done = (cnt == DT_W'(1));
    assign zero = (cnt == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Centre-aligned complementary PWM with double-buffered duty and dead-time insertion.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int N    = 8,
    parameter int DT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [N-1:0]    tri_in,
    input  logic [N-1:0]    duty_data,
    input  logic [DT_W-1:0] dead_time,
    input  logic            duty_valid,
    output logic            duty_ready,
    output logic            pwm_hi,
    output logic            pwm_lo,
    output logic            period_start
);

    logic [N-1:0]    shadow_duty;
    logic [DT_W-1:0] shadow_dt;
    logic            shadow_full;
    logic [N-1:0]    active_duty;
    logic [DT_W-1:0] active_dt;
    logic            raw_q;
    pwm_state_t      state;
    pwm_state_t      state_nxt;
    logic            tmr_load;
    logic            tmr_dec;
    logic            tmr_done;
    logic            tmr_zero;
    logic            trough;
    logic            xfer;
    logic            dt_zero;

    assign trough     = ena && (tri_in == '0);
    assign duty_ready = ~shadow_full;
    assign xfer       = duty_valid && duty_ready;
    assign dt_zero    = (active_dt == '0);

    // Shadow payload: captured on every accepted handshake, no reset needed.
    always_ff @(posedge clk) begin
        if (xfer) begin
            shadow_duty <= duty_data;
            shadow_dt   <= dead_time;
        end
    end

    // Shadow occupancy, active copy at the trough and the period marker.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_full  <= 1'b0;
            active_duty  <= '0;
            active_dt    <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= trough;
            if (trough && shadow_full) begin
                active_duty <= shadow_duty;
                active_dt   <= shadow_dt;
            end
            // Ready is low whenever the shadow is full, so a transfer and a
            // trough-copy never compete for the same word.
            if (xfer) begin
                shadow_full <= 1'b1;
            end else if (trough) begin
                shadow_full <= 1'b0;
            end
        end
    end

    // Registered unsigned compare of the triangle against the active duty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            raw_q <= 1'b0;
        end else begin
            raw_q <= (tri_in < active_duty);
        end
    end

    deadtime_timer #(
        .DT_W (DT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (active_dt),
        .dec      (tmr_dec),
        .done     (tmr_done),
        .zero     (tmr_zero)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= PWM_RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: enter a dead band on each raw edge; a raw reversal inside
    // the band returns to the side we came from, swallowing the short pulse.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        case (state)
            LO_ON: begin
                if (raw_q) begin
                    if (dt_zero) begin
                        state_nxt = HI_ON;
                    end else begin
                        state_nxt = DEAD_RISE;
                        tmr_load  = 1'b1;
                    end
                end
            end
            DEAD_RISE: begin
                if (!raw_q) begin
                    state_nxt = LO_ON;
                end else if (tmr_done || tmr_zero) begin
                    state_nxt = HI_ON;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            HI_ON: begin
                if (!raw_q) begin
                    if (dt_zero) begin
                        state_nxt = LO_ON;
                    end else begin
                        state_nxt = DEAD_FALL;
                        tmr_load  = 1'b1;
                    end
                end
            end
            DEAD_FALL: begin
                if (tmr_zero) begin
                    // Only reachable straight out of reset.
                    if (raw_q) begin
                        if (dt_zero) begin
                            state_nxt = HI_ON;
                        end else begin
                            state_nxt = DEAD_RISE;
                            tmr_load  = 1'b1;
                        end
                    end else begin
                        state_nxt = LO_ON;
                    end
                end else if (raw_q) begin
                    state_nxt = HI_ON;
                end else if (tmr_done) begin
                    state_nxt = LO_ON;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = PWM_RESET_STATE;
            end
        endcase
    end

    // Gate outputs are registered decodes of the next state, so they are glitch-free
    // and mutually exclusive by construction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            pwm_hi <= (state_nxt == HI_ON);
            pwm_lo <= (state_nxt == LO_ON);
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime driven by an in-bench 8-bit triangle counter.
module tb_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] tri_in;
    logic [7:0] duty_data;
    logic [3:0] dead_time;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_hi;
    logic       pwm_lo;
    logic       period_start;

    bit         tri_up;
    bit         chk_on;
    int         n_cmp;
    int         n_fail;
    logic       h_hi  [0:510];
    logic       h_lo  [0:510];
    logic       h_ps  [0:510];
    logic       h_rdy [0:510];
    int         n_acc;
    int         acc_d;

    always #5 clk = ~clk;

    pwm_deadtime #(.N(8), .DT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .tri_in       (tri_in),
        .duty_data    (duty_data),
        .dead_time    (dead_time),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .period_start (period_start)
    );

    // Both gates on together is never allowed.
    always @(negedge clk) begin
        if (chk_on) begin
            n_cmp++;
            assert (!(pwm_hi && pwm_lo)) else begin
                n_fail++;
                $display("FAIL overlap t=%0t: pwm_hi=%b pwm_lo=%b, required not both 1", $time, pwm_hi, pwm_lo);
            end
        end
    end

    // One clock; outputs sampled 1 time unit after the edge, then the triangle advances.
    task automatic step();
        @(posedge clk);
        #1;
        if (tri_up) begin
            if (tri_in == 8'hFF) begin tri_in = 8'hFE; tri_up = 1'b0; end
            else tri_in = tri_in + 8'd1;
        end else begin
            if (tri_in == 8'h00) begin tri_in = 8'h01; tri_up = 1'b1; end
            else tri_in = tri_in - 8'd1;
        end
    endtask

    task automatic run_to_trough();
        int k;
        k = 0;
        while (period_start !== 1'b1 && k < 600) begin
            step();
            k++;
        end
        n_cmp++;
        if (period_start !== 1'b1) begin
            n_fail++;
            $display("FAIL trough_timeout: period_start=%b after %0d cycles, required 1", period_start, k);
        end
    endtask

    // Steps one full period from a trough; index d = cycles after that trough.
    task automatic record_period(input int wr_d, input logic [7:0] wd, input logic [3:0] wdt,
                                 input int wr2_d, input logic [7:0] wd2, input logic [3:0] wdt2);
        logic pre;
        int   extra;
        n_acc = 0;
        acc_d = -1;
        extra = 0;
        h_hi[0] = pwm_hi; h_lo[0] = pwm_lo; h_ps[0] = period_start; h_rdy[0] = duty_ready;
        for (int d = 1; d <= 510; d++) begin
            if (d == wr_d)  begin duty_data = wd;  dead_time = wdt;  duty_valid = 1'b1; end
            if (d == wr2_d) begin duty_data = wd2; dead_time = wdt2; duty_valid = 1'b1; end
            pre = duty_ready;
            step();
            h_hi[d] = pwm_hi; h_lo[d] = pwm_lo; h_ps[d] = period_start; h_rdy[d] = duty_ready;
            if (duty_valid && pre) begin
                n_acc++;
                if (acc_d < 0) acc_d = d;
                duty_valid = 1'b0;
            end
        end
        for (int d = 1; d <= 509; d++) if (h_ps[d] !== 1'b0) extra++;
        n_cmp++;
        if (h_ps[510] !== 1'b1 || extra != 0) begin
            n_fail++;
            $display("FAIL period_start_pulse: end=%b extra=%0d, required end=1 extra=0", h_ps[510], extra);
        end
    endtask

    task automatic test_reset();
        int bad_hi, bad_lo, bad_rdy;
        rst = 1'b0;
        step();
        step();
        chk_on = 1'b1;
        n_cmp++; if (pwm_hi !== 1'b0)       begin n_fail++; $display("FAIL rst_pwm_hi: got %b want 0", pwm_hi); end
        n_cmp++; if (pwm_lo !== 1'b0)       begin n_fail++; $display("FAIL rst_pwm_lo: got %b want 0", pwm_lo); end
        n_cmp++; if (duty_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_ready: got %b want 1", duty_ready); end
        n_cmp++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL rst_period_start: got %b want 0", period_start); end
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (pwm_lo !== 1'b1)       begin n_fail++; $display("FAIL idle_pwm_lo_cycle2: got %b want 1", pwm_lo); end
        n_cmp++; if (pwm_hi !== 1'b0)       begin n_fail++; $display("FAIL idle_pwm_hi_cycle2: got %b want 0", pwm_hi); end
        run_to_trough();
        record_period(-1, 8'd0, 4'd0, -1, 8'd0, 4'd0);
        bad_hi = 0; bad_lo = 0; bad_rdy = 0;
        for (int d = 1; d <= 510; d++) begin
            if (h_hi[d] !== 1'b0)  bad_hi++;
            if (h_lo[d] !== 1'b1)  bad_lo++;
            if (h_rdy[d] !== 1'b1) bad_rdy++;
        end
        n_cmp++; if (bad_hi != 0)  begin n_fail++; $display("FAIL idle_hi: %0d cycles high, required 0", bad_hi); end
        n_cmp++; if (bad_lo != 0)  begin n_fail++; $display("FAIL idle_lo: %0d cycles low, required 0", bad_lo); end
        n_cmp++; if (bad_rdy != 0) begin n_fail++; $display("FAIL idle_ready: %0d cycles not ready, required 0", bad_rdy); end
    endtask

    task automatic test_duty128();
        logic exp_hi, exp_lo;
        record_period(1, 8'd128, 4'd3, -1, 8'd0, 4'd0);
        n_cmp++; if (acc_d != 1)        begin n_fail++; $display("FAIL d128_accept: at %0d, required 1", acc_d); end
        n_cmp++; if (h_rdy[1] !== 1'b0 || h_rdy[509] !== 1'b0) begin n_fail++; $display("FAIL d128_ready_full: %b/%b want 0/0", h_rdy[1], h_rdy[509]); end
        n_cmp++; if (h_rdy[510] !== 1'b1) begin n_fail++; $display("FAIL d128_ready_trough: got %b want 1", h_rdy[510]); end
        n_cmp++; if (h_hi[200] !== 1'b0 || h_lo[200] !== 1'b1) begin n_fail++; $display("FAIL d128_not_yet_active: hi=%b lo=%b want 0/1", h_hi[200], h_lo[200]); end
        record_period(-1, 8'd0, 4'd0, -1, 8'd0, 4'd0);
        for (int d = 1; d <= 510; d++) begin
            exp_hi = (d >= 5 && d <= 128) || (d >= 387);
            exp_lo = (d <= 1) || (d >= 132 && d <= 383);
            n_cmp++;
            if (h_hi[d] !== exp_hi || h_lo[d] !== exp_lo) begin
                n_fail++;
                $display("FAIL d128_wave d=%0d: hi=%b lo=%b, required hi=%b lo=%b", d, h_hi[d], h_lo[d], exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_shadow_full();
        int   pd  [8] = '{64, 65, 66, 67, 447, 448, 449, 450};
        bit   ph  [8] = '{1, 1, 0, 0, 0, 0, 1, 1};
        logic pv  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic got;
        record_period(1, 8'd64, 4'd2, 100, 8'd192, 4'd1);
        n_cmp++; if (n_acc != 1 || acc_d != 1) begin n_fail++; $display("FAIL sf_second_write: n=%0d at %0d, required 1 at 1", n_acc, acc_d); end
        n_cmp++; if (h_rdy[509] !== 1'b0) begin n_fail++; $display("FAIL sf_ready_held: got %b want 0", h_rdy[509]); end
        n_cmp++; if (h_hi[100] !== 1'b1)  begin n_fail++; $display("FAIL sf_old_duty: hi=%b want 1", h_hi[100]); end
        record_period(-1, 8'd0, 4'd0, -1, 8'd0, 4'd0);
        n_cmp++; if (n_acc != 1 || acc_d != 1) begin n_fail++; $display("FAIL sf_third_write: n=%0d at %0d, required 1 at 1", n_acc, acc_d); end
        n_cmp++; if (h_rdy[1] !== 1'b0 || h_rdy[510] !== 1'b1) begin n_fail++; $display("FAIL sf_ready_b: %b/%b want 0/1", h_rdy[1], h_rdy[510]); end
        for (int i = 0; i < 8; i++) begin
            got = ph[i] ? h_hi[pd[i]] : h_lo[pd[i]];
            n_cmp++;
            if (got !== pv[i]) begin
                n_fail++;
                $display("FAIL sf_edge_%s d=%0d: got %b want %b", ph[i] ? "hi" : "lo", pd[i], got, pv[i]);
            end
        end
    endtask

    task automatic test_same_cycle_trough();
        int   pd [4] = '{192, 193, 193, 194};
        bit   ph [4] = '{1, 1, 0, 0};
        logic pv [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   qd [4] = '{32, 33, 34, 35};
        bit   qh [4] = '{1, 1, 0, 0};
        logic qv [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic got;
        record_period(510, 8'd32, 4'd2, -1, 8'd0, 4'd0);
        n_cmp++; if (acc_d != 510)        begin n_fail++; $display("FAIL st_accept: at %0d, required 510", acc_d); end
        n_cmp++; if (h_rdy[510] !== 1'b0) begin n_fail++; $display("FAIL st_ready: got %b want 0", h_rdy[510]); end
        record_period(-1, 8'd0, 4'd0, -1, 8'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            got = ph[i] ? h_hi[pd[i]] : h_lo[pd[i]];
            n_cmp++;
            if (got !== pv[i]) begin n_fail++; $display("FAIL st_old_duty d=%0d: got %b want %b", pd[i], got, pv[i]); end
        end
        n_cmp++; if (h_rdy[509] !== 1'b0 || h_rdy[510] !== 1'b1) begin n_fail++; $display("FAIL st_ready_d: %b/%b want 0/1", h_rdy[509], h_rdy[510]); end
        record_period(1, 8'd2, 4'd5, -1, 8'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            got = qh[i] ? h_hi[qd[i]] : h_lo[qd[i]];
            n_cmp++;
            if (got !== qv[i]) begin n_fail++; $display("FAIL st_new_duty d=%0d: got %b want %b", qd[i], got, qv[i]); end
        end
    endtask

    task automatic test_swallow();
        int   bad;
        logic exp_lo;
        // Period with duty 2 / dead time 5 now active.
        record_period(-1, 8'd0, 4'd0, -1, 8'd0, 4'd0);
        bad = 0;
        for (int d = 3; d <= 510; d++) if (h_hi[d] !== 1'b0) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL sw_hi_first: %0d cycles high, required 0", bad); end
        n_cmp++; if (h_lo[7] !== 1'b0 || h_lo[8] !== 1'b1) begin n_fail++; $display("FAIL sw_fall_gap: lo7=%b lo8=%b want 0/1", h_lo[7], h_lo[8]); end
        n_cmp++; if (h_lo[510] !== 1'b0) begin n_fail++; $display("FAIL sw_rise_gap: got %b want 0", h_lo[510]); end
        record_period(1, 8'd200, 4'd3, -1, 8'd0, 4'd0);
        for (int d = 1; d <= 510; d++) begin
            exp_lo = !(d <= 2 || d == 510);
            n_cmp++;
            if (h_hi[d] !== 1'b0 || h_lo[d] !== exp_lo) begin
                n_fail++;
                $display("FAIL sw_wave d=%0d: hi=%b lo=%b, required hi=0 lo=%b", d, h_hi[d], h_lo[d], exp_lo);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad_hi, bad_lo;
        for (int i = 0; i < 50; i++) step();
        n_cmp++; if (duty_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_pre: got %b want 1", duty_ready); end
        duty_data = 8'd100; dead_time = 4'd1; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        n_cmp++; if (duty_ready !== 1'b0) begin n_fail++; $display("FAIL rm_shadow_loaded: got %b want 0", duty_ready); end
        for (int i = 0; i < 49; i++) step();
        n_cmp++; if (pwm_hi !== 1'b1) begin n_fail++; $display("FAIL rm_hi_on: got %b want 1", pwm_hi); end
        rst = 1'b0;
        step();
        n_cmp++; if (pwm_hi !== 1'b0)       begin n_fail++; $display("FAIL rm_pwm_hi: got %b want 0", pwm_hi); end
        n_cmp++; if (pwm_lo !== 1'b0)       begin n_fail++; $display("FAIL rm_pwm_lo: got %b want 0", pwm_lo); end
        n_cmp++; if (duty_ready !== 1'b1)   begin n_fail++; $display("FAIL rm_ready: got %b want 1", duty_ready); end
        n_cmp++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL rm_period_start: got %b want 0", period_start); end
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (pwm_lo !== 1'b1) begin n_fail++; $display("FAIL rm_lo_after: got %b want 1", pwm_lo); end
        run_to_trough();
        record_period(-1, 8'd0, 4'd0, -1, 8'd0, 4'd0);
        bad_hi = 0; bad_lo = 0;
        for (int d = 1; d <= 510; d++) begin
            if (h_hi[d] !== 1'b0) bad_hi++;
            if (h_lo[d] !== 1'b1) bad_lo++;
        end
        n_cmp++; if (bad_hi != 0) begin n_fail++; $display("FAIL rm_idle_hi: %0d cycles high, required 0", bad_hi); end
        n_cmp++; if (bad_lo != 0) begin n_fail++; $display("FAIL rm_idle_lo: %0d cycles low, required 0", bad_lo); end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        chk_on     = 1'b0;
        rst        = 1'b0;
        ena        = 1'b1;
        tri_in     = 8'd0;
        tri_up     = 1'b1;
        duty_data  = 8'd0;
        dead_time  = 4'd0;
        duty_valid = 1'b0;
        test_reset();
        test_duty128();
        test_shadow_full();
        test_same_cycle_trough();
        test_swallow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
